// File: rtl/i2c_regbank_pkg.sv
// Shared definitions for the I2C slave register bank: FSM encoding, default widths
// and the byte returned when reading an unmapped address.
package i2c_regbank_pkg;

  localparam int DEF_REG_W = 16;
  localparam int DEF_PTR_W = 8;

  localparam logic [7:0] UNMAPPED_BYTE = 8'hFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PTR   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_RLOAD = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_regbank_rdbuf.sv
// Read snapshot buffer: captures a whole register in one clock and hands it out
// MSB byte first, so live source changes cannot tear a register mid-read.
module i2c_regbank_rdbuf
  import i2c_regbank_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [REG_W-1:0] i_load_val,
  input  logic             i_next,
  output logic [7:0]       o_tx_byte
);

  logic [REG_W-1:0] r_pend;
  logic [7:0]       r_tx;

  // r_pend holds the bytes not yet presented, left-aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      r_tx   <= UNMAPPED_BYTE;
    end else if (i_load) begin
      r_tx   <= i_load_val[REG_W-1 -: 8];
      r_pend <= i_load_val << 8;
    end else if (i_next) begin
      r_tx   <= r_pend[REG_W-1 -: 8];
      r_pend <= r_pend << 8;
    end
  end

  assign o_tx_byte = r_tx;

endmodule

// File: rtl/i2c_slave_regbank.sv
// Parametrised register bank behind the byte-level I2C slave controller: pointer
// decode, write assembly with atomic commit, and snapshot-based reads.
module i2c_slave_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int                    N_RW     = 8,
  parameter int                    N_RO     = 4,
  parameter int                    REG_W    = DEF_REG_W,
  parameter int                    PTR_W    = DEF_PTR_W,
  parameter int                    AUTO_INC = 1,
  parameter logic [N_RW*REG_W-1:0] RW_RST   = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i2c_start,
  input  logic                    i2c_stop,
  input  logic                    i2c_data_vld,
  input  logic                    i2c_r_w,
  input  logic [7:0]              i2c_rx_byte,
  output logic [7:0]              i2c_tx_byte,
  output logic                    i2c_stretch,
  input  logic [N_RO*REG_W-1:0]   ro_data,
  output logic [N_RW*REG_W-1:0]   rw_data,
  output logic [N_RW-1:0]         rw_update,
  output logic                    wr_err
);

  localparam int               NB       = REG_W / 8;
  localparam int               N_TOT    = N_RW + N_RO;
  localparam int               CNT_W    = 3;
  localparam int               RW_IW    = clog2_min1(N_RW);
  localparam int               RO_IW    = clog2_min1(N_RO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);
  localparam logic [PTR_W:0]   RW_END   = (PTR_W + 1)'(N_RW);
  localparam logic [PTR_W:0]   TOT_END  = (PTR_W + 1)'(N_TOT);
  localparam logic [PTR_W:0]   TOT_LAST = (PTR_W + 1)'(N_TOT - 1);

  logic [2:0]       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [REG_W-1:0] r_asm, w_asm_nxt, w_asm_shift;
  logic [REG_W-1:0] r_rw [N_RW];
  logic [N_RW-1:0]  r_rw_update;
  logic             r_wr_err;

  logic             w_is_rw, w_is_ro;
  logic [RW_IW-1:0] w_rw_idx;
  logic [RO_IW-1:0] w_ro_idx;
  logic             w_commit, w_drop;
  logic             w_rd_load, w_rd_next;
  logic [REG_W-1:0] w_rd_val;

  // Address decode; the extra MSB lets N_TOT reach 2**PTR_W.
  assign w_is_rw   = {1'b0, r_ptr} < RW_END;
  assign w_is_ro   = !w_is_rw && ({1'b0, r_ptr} < TOT_END);
  assign w_rw_idx  = RW_IW'(r_ptr);
  assign w_ro_idx  = RO_IW'(r_ptr - PTR_W'(N_RW));
  assign w_ptr_inc = ({1'b0, r_ptr} >= TOT_LAST) ? '0 : r_ptr + PTR_W'(1);

  assign w_asm_shift = (r_asm << 8) | REG_W'(i2c_rx_byte);

  always_comb begin
    w_rd_val = {NB{UNMAPPED_BYTE}};
    if (w_is_rw) begin
      w_rd_val = r_rw[w_rw_idx];
    end else if (w_is_ro) begin
      w_rd_val = ro_data[w_ro_idx*REG_W +: REG_W];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    w_rd_next   = 1'b0;
    w_rd_load   = (r_state == ST_RLOAD);

    // START outranks a coincident byte and discards any partial register.
    if (i2c_start) begin
      w_state_nxt = i2c_r_w ? ST_RLOAD : ST_PTR;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_PTR: begin
          if (i2c_data_vld) begin
            w_ptr_nxt   = PTR_W'(i2c_rx_byte);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (i2c_data_vld) begin
            w_asm_nxt = w_asm_shift;
            if (r_cnt == CNT_LAST) begin
              w_cnt_nxt = '0;
              w_commit  = w_is_rw;
              w_drop    = !w_is_rw;
              if (AUTO_INC != 0) w_ptr_nxt = w_ptr_inc;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        ST_RLOAD: begin
          w_state_nxt = ST_RDATA;
        end
        ST_RDATA: begin
          if (i2c_data_vld) begin
            if (r_cnt == CNT_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_RLOAD;
              if (AUTO_INC != 0) w_ptr_nxt = w_ptr_inc;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
              w_rd_next = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      // A STOP on the final byte still lets that byte commit above.
      if (i2c_stop) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational blocks above use blocking ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_asm       <= '0;
      r_rw_update <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_asm       <= w_asm_nxt;
      r_rw_update <= w_commit ? (N_RW'(1) << w_rw_idx) : '0;
      r_wr_err    <= w_drop;
    end
  end

  // NOTE: this register array is deliberately reset, because RW_RST defines the
  // power-up contents the downstream control logic relies on.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_RW; i++) begin
        r_rw[i] <= RW_RST[i*REG_W +: REG_W];
      end
    end else if (w_commit) begin
      r_rw[w_rw_idx] <= w_asm_nxt;
    end
  end

  i2c_regbank_rdbuf #(
    .REG_W (REG_W)
  ) u_rdbuf (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_rd_load),
    .i_load_val (w_rd_val),
    .i_next     (w_rd_next),
    .o_tx_byte  (i2c_tx_byte)
  );

  for (genvar g = 0; g < N_RW; g++) begin : g_rw_flat
    assign rw_data[g*REG_W +: REG_W] = r_rw[g];
  end

  assign rw_update   = r_rw_update;
  assign wr_err      = r_wr_err;
  assign i2c_stretch = (r_state == ST_RLOAD);

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: byte-level write/read transactions with
// hand-computed register contents and transmit bytes.
module tb_i2c_slave_regbank;

  logic         clk;
  logic         rstn;
  logic         i2c_start;
  logic         i2c_stop;
  logic         i2c_data_vld;
  logic         i2c_r_w;
  logic [7:0]   i2c_rx_byte;
  logic [7:0]   i2c_tx_byte;
  logic         i2c_stretch;
  logic [63:0]  ro_data;
  logic [127:0] rw_data;
  logic [7:0]   rw_update;
  logic         wr_err;

  logic [127:0] exp_rw;
  int           n_checks;
  int           n_fail;

  i2c_slave_regbank dut (
    .clk          (clk),
    .rstn         (rstn),
    .i2c_start    (i2c_start),
    .i2c_stop     (i2c_stop),
    .i2c_data_vld (i2c_data_vld),
    .i2c_r_w      (i2c_r_w),
    .i2c_rx_byte  (i2c_rx_byte),
    .i2c_tx_byte  (i2c_tx_byte),
    .i2c_stretch  (i2c_stretch),
    .ro_data      (ro_data),
    .rw_data      (rw_data),
    .rw_update    (rw_update),
    .wr_err       (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic pulse_start(input logic rw);
    i2c_start = 1'b1;
    i2c_r_w   = rw;
    @(negedge clk);
    i2c_start = 1'b0;
  endtask

  task automatic pulse_stop();
    i2c_stop = 1'b1;
    @(negedge clk);
    i2c_stop = 1'b0;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    i2c_rx_byte  = b;
    i2c_data_vld = 1'b1;
    @(negedge clk);
    i2c_data_vld = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    pulse_start(1'b0);
    pulse_byte(p);
  endtask

  // Expects to be entered with the bank in its load (stretch) cycle.
  task automatic read_word(input string tag, input logic [15:0] exp);
    check({tag, "_stretch"}, i2c_stretch, 1);
    @(negedge clk);
    check({tag, "_hi"}, i2c_tx_byte, exp[15:8]);
    check({tag, "_unstretch"}, i2c_stretch, 0);
    pulse_byte(8'h00);
    check({tag, "_lo"}, i2c_tx_byte, exp[7:0]);
    pulse_byte(8'h00);
    check({tag, "_restretch"}, i2c_stretch, 1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_rw       = '0;
    rstn         = 1'b0;
    i2c_start    = 1'b0;
    i2c_stop     = 1'b0;
    i2c_data_vld = 1'b0;
    i2c_r_w      = 1'b0;
    i2c_rx_byte  = 8'h00;
    ro_data      = {16'hBEEF, 16'h0000, 16'h0000, 16'h1234};
    repeat (3) @(negedge clk);

    check("rst_rw_data", rw_data, exp_rw);
    check("rst_update", rw_update, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_stretch", i2c_stretch, 0);
    check("rst_tx", i2c_tx_byte, 8'hFF);
    rstn = 1'b1;
    @(negedge clk);

    // Read register 0 straight after reset.
    set_ptr(8'h00);
    pulse_start(1'b1);
    read_word("t1_reg0", 16'h0000);
    check("t1_no_update", rw_update, 0);
    pulse_stop();

    // Plain two-byte write to register 2.
    set_ptr(8'h02);
    pulse_byte(8'hAB);
    check("t2_no_early_update", rw_update, 0);
    pulse_byte(8'hCD);
    exp_rw[2*16 +: 16] = 16'hABCD;
    check("t2_reg2", rw_data[47:32], 16'hABCD);
    check("t2_update", rw_update, 8'b0000_0100);
    @(negedge clk);
    check("t2_update_1clk", rw_update, 0);
    pulse_stop();

    // Auto-increment from RW reg 7 into RO reg 8, which is dropped.
    set_ptr(8'h07);
    pulse_byte(8'h11);
    pulse_byte(8'h22);
    exp_rw[7*16 +: 16] = 16'h1122;
    check("t3_update7", rw_update, 8'b1000_0000);
    pulse_byte(8'h33);
    pulse_byte(8'h44);
    check("t3_wr_err", wr_err, 1);
    check("t3_no_update", rw_update, 0);
    check("t3_rw_data", rw_data, exp_rw);
    @(negedge clk);
    check("t3_wr_err_1clk", wr_err, 0);
    pulse_stop();

    // Write at the last address wraps the pointer to register 0.
    set_ptr(8'h0B);
    pulse_byte(8'hDE);
    pulse_byte(8'hAD);
    check("t3w_wr_err", wr_err, 1);
    pulse_byte(8'h9A);
    pulse_byte(8'hBC);
    exp_rw[0 +: 16] = 16'h9ABC;
    check("t3w_update0", rw_update, 8'b0000_0001);
    check("t3w_rw_data", rw_data, exp_rw);
    pulse_stop();

    // RO read with the live value changing between bytes.
    set_ptr(8'h08);
    pulse_start(1'b1);
    check("t4_stretch", i2c_stretch, 1);
    @(negedge clk);
    check("t4_hi", i2c_tx_byte, 8'h12);
    ro_data[15:0] = 16'h5678;
    pulse_byte(8'h00);
    check("t4_lo_snapshot", i2c_tx_byte, 8'h34);
    pulse_stop();

    // Partial write cut by STOP; pointer keeps the written value.
    set_ptr(8'h01);
    pulse_byte(8'h55);
    pulse_stop();
    check("t5_no_update", rw_update, 0);
    check("t5_rw_data", rw_data, exp_rw);
    pulse_start(1'b1);
    read_word("t5_reg1", 16'h0000);
    pulse_stop();

    // STOP coincident with the final byte still commits.
    set_ptr(8'h04);
    pulse_byte(8'h5A);
    i2c_rx_byte  = 8'hA5;
    i2c_data_vld = 1'b1;
    i2c_stop     = 1'b1;
    @(negedge clk);
    i2c_data_vld = 1'b0;
    i2c_stop     = 1'b0;
    exp_rw[4*16 +: 16] = 16'h5AA5;
    check("t5s_update4", rw_update, 8'b0001_0000);
    check("t5s_rw_data", rw_data, exp_rw);
    pulse_byte(8'h77);
    check("t5s_idle_byte_ignored", rw_update, 0);

    // START coincident with a byte: the byte is ignored.
    set_ptr(8'h06);
    pulse_byte(8'h11);
    i2c_start    = 1'b1;
    i2c_r_w      = 1'b0;
    i2c_rx_byte  = 8'h22;
    i2c_data_vld = 1'b1;
    @(negedge clk);
    i2c_start    = 1'b0;
    i2c_data_vld = 1'b0;
    check("t5c_no_update", rw_update, 0);
    pulse_byte(8'h06);
    pulse_byte(8'h33);
    pulse_byte(8'h44);
    exp_rw[6*16 +: 16] = 16'h3344;
    check("t5c_update6", rw_update, 8'b0100_0000);
    check("t5c_rw_data", rw_data, exp_rw);
    pulse_stop();

    // Last RO register, then auto-increment wraps to register 0.
    set_ptr(8'h0B);
    pulse_start(1'b1);
    read_word("t6_ro3", 16'hBEEF);
    read_word("t6_wrap_reg0", 16'h9ABC);
    pulse_stop();

    // Unmapped address reads all-ones.
    set_ptr(8'h0C);
    pulse_start(1'b1);
    read_word("t6_unmapped", 16'hFFFF);
    pulse_stop();

    // Reset in the middle of a read.
    set_ptr(8'h00);
    pulse_start(1'b1);
    @(negedge clk);
    check("t6_pre_rst_tx", i2c_tx_byte, 8'h9A);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_tx", i2c_tx_byte, 8'hFF);
    check("t6_rst_stretch", i2c_stretch, 0);
    check("t6_rst_rw_data", rw_data, 0);
    check("t6_rst_update", rw_update, 0);
    check("t6_rst_wr_err", wr_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_ptr(8'h00);
    pulse_start(1'b1);
    read_word("t6_post_rst_reg0", 16'h0000);
    pulse_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
